// File: rtl/rect_adc_pkg.sv
// Purpose: shared FSM state encoding and 100 MHz timing defaults for the rectifier ADC sequencer.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package rect_adc_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_START    = 2'd1;
    localparam logic [1:0] ST_WAIT_EOC = 2'd2;
    localparam logic [1:0] ST_CAPTURE  = 2'd3;

    // 100 kHz conversion rate, 40 ns CONVST, 5 us EOC budget at 100 MHz
    localparam int DEF_PERIOD       = 1000;
    localparam int DEF_CONVST_WIDTH = 4;
    localparam int DEF_TIMEOUT      = 500;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: 2-FF synchronizer plus one delay flop, giving a single-clock rising-edge pulse.
// Latency: 2-3 clocks from pin to rise, depending on where the pin edge lands.
// Backpressure: none; every synchronized edge produces exactly one pulse.
module sync_edge_detect (
    input  logic core_clk,
    input  logic arst_n,
    input  logic d,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/rect_adc_sequencer.sv
// Purpose: CONVST/EOC initiator for one 8-bit rectifier ADC; optional averaging under RECT_ADC_AVG_EN.
// Latency: o_valid rises 2 clocks after the synchronized EOC edge.
// Backpressure: none; a period tick arriving while busy is dropped and flagged as overrun.
module rect_adc_sequencer
    import rect_adc_pkg::*;
#(
    parameter int N_BIT        = 8,
    parameter int PERIOD       = DEF_PERIOD,
    parameter int CONVST_WIDTH = DEF_CONVST_WIDTH,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int AVG_LOG2     = 2
) (
    input  logic             i_clock,
    input  logic             i_RESET,
    input  logic             i_enable,
    input  logic             i_clear_err,
    input  logic             i_eoc,
    input  logic [N_BIT-1:0] i_data,
    output logic             o_convst,
    output logic [N_BIT-1:0] o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             o_overrun
);

    localparam int PW = cnt_width(PERIOD);
    localparam int CW = cnt_width(CONVST_WIDTH);
    localparam int TW = cnt_width(TIMEOUT);

    logic [1:0]       state;
    logic [PW-1:0]    period_cnt;
    logic [CW-1:0]    cw_cnt;
    logic [TW-1:0]    to_cnt;
    logic [N_BIT-1:0] cap_dat;
    logic             tick;
    logic             eoc_rise;
    logic             timeout_evt;
    logic             overrun_evt;

    sync_edge_detect u_eoc_sync (
        .core_clk (i_clock),
        .arst_n   (i_RESET),
        .d        (i_eoc),
        .rise     (eoc_rise)
    );

    // Free-running regardless of enable so start times stay phase-locked.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            period_cnt <= '0;
        end else if (period_cnt == PW'(PERIOD - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    assign tick        = (period_cnt == PW'(PERIOD - 1));
    assign timeout_evt = (state == ST_WAIT_EOC) && !eoc_rise && (to_cnt == TW'(TIMEOUT - 1));
    assign overrun_evt = tick && (state != ST_IDLE);
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state    <= ST_IDLE;
            cw_cnt   <= '0;
            to_cnt   <= '0;
            o_convst <= 1'b0;
            cap_dat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick && i_enable) begin
                        state    <= ST_START;
                        o_convst <= 1'b1;
                        cw_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cw_cnt == CW'(CONVST_WIDTH - 1)) begin
                        state    <= ST_WAIT_EOC;
                        o_convst <= 1'b0;
                        to_cnt   <= '0;
                    end else begin
                        cw_cnt <= cw_cnt + CW'(1);
                    end
                end
                ST_WAIT_EOC: begin
                    // i_data is guaranteed stable while EOC is high, so it is safe to sample here
                    if (eoc_rise) begin
                        state   <= ST_CAPTURE;
                        cap_dat <= i_data;
                    end else if (timeout_evt) begin
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same clock as a clear must not be lost.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (timeout_evt) begin
                o_timeout <= 1'b1;
            end else if (i_clear_err) begin
                o_timeout <= 1'b0;
            end
            if (overrun_evt) begin
                o_overrun <= 1'b1;
            end else if (i_clear_err) begin
                o_overrun <= 1'b0;
            end
        end
    end

`ifdef RECT_ADC_AVG_EN
    localparam int AW = N_BIT + AVG_LOG2;

    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_sum;
    logic [AVG_LOG2-1:0] smp_cnt;

    assign acc_sum = acc + AW'(cap_dat);

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            acc     <= '0;
            smp_cnt <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (state == ST_CAPTURE) begin
                if (smp_cnt == {AVG_LOG2{1'b1}}) begin
                    o_data  <= acc_sum[AW-1:AVG_LOG2];
                    o_valid <= 1'b1;
                    acc     <= '0;
                    smp_cnt <= '0;
                end else begin
                    acc     <= acc_sum;
                    smp_cnt <= smp_cnt + AVG_LOG2'(1);
                end
            end else if (timeout_evt || ((state == ST_IDLE) && !i_enable)) begin
                // A lost sample would bias the average, so restart the window.
                acc     <= '0;
                smp_cnt <= '0;
            end
        end
    end
`else
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= (state == ST_CAPTURE);
            if (state == ST_CAPTURE) begin
                o_data <= cap_dat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rect_adc_sequencer.sv
// Purpose: directed self-checking bench for rect_adc_sequencer with a behavioural ADC model per instance.
// Latency: n/a. Backpressure: n/a.
module tb_rect_adc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       en1 = 1'b0;
    logic       clr1 = 1'b0;
    logic       eoc1 = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic       convst1, v1, busy1, to1, ov1;
    logic [7:0] q1;

    logic       en2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       eoc2 = 1'b0;
    logic [7:0] d2 = 8'h00;
    logic       convst2, v2, busy2, to2, ov2;
    logic [7:0] q2;

    int         m1_delay = 5;
    bit         m1_never = 1'b1;
    logic [7:0] m1_data = 8'hA5;
    int         m2_delay = 25;
    bit         m2_never = 1'b1;
    logic [7:0] m2_data = 8'h5A;

    int n_chk = 0;
    int n_pass = 0;

    rect_adc_sequencer #(.N_BIT(8), .PERIOD(20), .CONVST_WIDTH(2), .TIMEOUT(10), .AVG_LOG2(2)) dut (
        .i_clock(clk), .i_RESET(rst_n), .i_enable(en1), .i_clear_err(clr1),
        .i_eoc(eoc1), .i_data(d1), .o_convst(convst1), .o_data(q1), .o_valid(v1),
        .o_busy(busy1), .o_timeout(to1), .o_overrun(ov1)
    );

    rect_adc_sequencer #(.N_BIT(8), .PERIOD(20), .CONVST_WIDTH(2), .TIMEOUT(40), .AVG_LOG2(2)) dut_ovr (
        .i_clock(clk), .i_RESET(rst_n), .i_enable(en2), .i_clear_err(clr2),
        .i_eoc(eoc2), .i_data(d2), .o_convst(convst2), .o_data(q2), .o_valid(v2),
        .o_busy(busy2), .o_timeout(to2), .o_overrun(ov2)
    );

    always #5 clk = ~clk;

    // ADC models: EOC rises m*_delay clocks after the CONVST fall, held for 3 clocks.
    always begin
        @(negedge convst1);
        if (!m1_never) begin
            d1 = m1_data;
            repeat (m1_delay) @(posedge clk);
            #2 eoc1 = 1'b1;
            repeat (3) @(posedge clk);
            #2 eoc1 = 1'b0;
        end
    end

    always begin
        @(negedge convst2);
        if (!m2_never) begin
            d2 = m2_data;
            repeat (m2_delay) @(posedge clk);
            #2 eoc2 = 1'b1;
            repeat (3) @(posedge clk);
            #2 eoc2 = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_rise1(input int budget);
        int n = 0;
        while (convst1 !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("wait_convst1", convst1, 1);
    endtask

`ifndef RECT_ADC_AVG_EN
    // Entered on the sample just after a CONVST rise; leaves on the next rise.
    task automatic run_nominal(input logic [7:0] exp_d);
        chk("nom_convst_hi1", convst1, 1);
        chk("nom_busy", busy1, 1);
        step();
        chk("nom_convst_hi2", convst1, 1);
        step();
        chk("nom_convst_fall", convst1, 0);
        repeat (8) step();
        chk("nom_valid_early", v1, 0);
        step();
        chk("nom_valid", v1, 1);
        chk("nom_data", q1, exp_d);
        step();
        chk("nom_valid_pulse", v1, 0);
        chk("nom_flags", {to1, ov1}, 0);
        repeat (7) step();
        chk("nom_convst_gap", convst1, 0);
        step();
        chk("nom_period", convst1, 1);
    endtask
`else
    task automatic conv1(input logic [7:0] d, input bit never, input logic exp_v, input logic [7:0] exp_d);
        wait_rise1(40);
        m1_data  = d;
        m1_never = never;
        repeat (11) step();
        chk("avg_valid", v1, exp_v);
        if (exp_v) chk("avg_data", q1, exp_d);
    endtask
`endif

    initial begin
        int seen;
        #12;
        chk("rst_outputs", {convst1, v1, busy1, to1, ov1, q1}, 0);
        #11 rst_n = 1'b1;
        step();
        chk("post_rst_idle", {convst1, v1, busy1, to1, ov1, q1}, 0);

`ifndef RECT_ADC_AVG_EN
        // Nominal handshake over two periods
        m1_never = 1'b0;
        m1_data  = 8'hA5;
        en1 = 1'b1;
        wait_rise1(40);
        run_nominal(8'hA5);
        run_nominal(8'hA5);

        // Timeout, restart on next tick, clear
        m1_never = 1'b1;
        step();
        step();
        chk("to_fall", convst1, 0);
        seen = 0;
        repeat (9) begin
            step();
            seen = seen | int'(v1);
        end
        chk("to_early", to1, 0);
        step();
        chk("to_set", to1, 1);
        chk("to_idle", busy1, 0);
        chk("to_no_valid", seen | int'(v1), 0);
        repeat (7) step();
        chk("to_gap", convst1, 0);
        step();
        chk("to_restart", convst1, 1);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        chk("to_clear", to1, 0);

        // Clear in the same clock as the timeout: set wins
        repeat (10) step();
        chk("sim_pre", to1, 0);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        chk("sim_set_wins", to1, 1);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        chk("sim_clear_after", to1, 0);
        chk("sim_no_overrun", ov1, 0);

        // Enable drop during START: conversion completes, no further starts
        m1_never = 1'b0;
        m1_data  = 8'h3C;
        wait_rise1(30);
        en1 = 1'b0;
        repeat (11) step();
        chk("en_drop_valid", v1, 1);
        chk("en_drop_data", q1, 8'h3C);
        seen = 0;
        repeat (45) begin
            step();
            seen = seen | int'(convst1);
        end
        chk("en_drop_no_start", seen, 0);

        // Asynchronous reset during WAIT_EOC
        en1 = 1'b1;
        wait_rise1(30);
        repeat (4) step();
        chk("rst_wait_busy", busy1, 1);
        chk("rst_wait_data", q1, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {convst1, v1, busy1, to1, ov1, q1}, 0);
        en1 = 1'b0;
        repeat (3) step();
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            step();
            seen = seen | int'(v1) | int'(convst1);
        end
        chk("rst_quiet", seen, 0);
        m1_data = 8'h96;
        en1 = 1'b1;
        wait_rise1(30);
        run_nominal(8'h96);

        // Overrun on the long-timeout instance
        m2_never = 1'b0;
        en2 = 1'b1;
        seen = 0;
        while (convst2 !== 1'b1 && seen < 40) begin
            step();
            seen++;
        end
        chk("wait_convst2", convst2, 1);
        repeat (19) step();
        chk("ovr_pre", ov2, 0);
        step();
        chk("ovr_set", ov2, 1);
        chk("ovr_tick_dropped", convst2, 0);
        repeat (10) step();
        chk("ovr_valid_early", v2, 0);
        step();
        chk("ovr_valid", v2, 1);
        chk("ovr_data", q2, 8'h5A);
        repeat (8) step();
        chk("ovr_gap", convst2, 0);
        step();
        chk("ovr_next_start", convst2, 1);
        chk("ovr_no_timeout", to2, 0);
`else
        // Averaging: 10,11,12,14 -> 11; two samples, timeout, then 4 x 4 -> 4
        m1_never = 1'b0;
        en1 = 1'b1;
        conv1(8'd10, 1'b0, 1'b0, 8'd0);
        conv1(8'd11, 1'b0, 1'b0, 8'd0);
        conv1(8'd12, 1'b0, 1'b0, 8'd0);
        conv1(8'd14, 1'b0, 1'b1, 8'd11);
        conv1(8'd7, 1'b0, 1'b0, 8'd0);
        conv1(8'd7, 1'b0, 1'b0, 8'd0);
        conv1(8'd0, 1'b1, 1'b0, 8'd0);
        chk("avg_timeout", to1, 1);
        conv1(8'd4, 1'b0, 1'b0, 8'd0);
        conv1(8'd4, 1'b0, 1'b0, 8'd0);
        conv1(8'd4, 1'b0, 1'b0, 8'd0);
        conv1(8'd4, 1'b0, 1'b1, 8'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
